// File: rtl/serial_sub_seq.sv
// Bit-serial WIDTH-bit subtractor sequencer driving one external full-subtractor cell, LSB first.
// Latency: done pulses WIDTH+1 cycles after the accepting edge; issue interval is WIDTH+2 cycles.
// Backpressure: start is accepted only while ready (IDLE); start in RUN/DONE is dropped, never queued.
module serial_sub_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow_out,
  output logic             ovf,
  output logic             fs_a,
  output logic             fs_b,
  output logic             fs_c,
  input  logic             fs_diff,
  input  logic             fs_borr
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             brw_q;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      r_sr       <= '0;
      brw_q      <= 1'b0;
      cnt        <= '0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      result     <= '0;
      borrow_out <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            brw_q <= 1'b0;
            cnt   <= '0;
            a_msb <= a_in[WIDTH-1];
            b_msb <= b_in[WIDTH-1];
            state <= RUN;
          end
        end
        RUN: begin
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          r_sr  <= {fs_diff, r_sr[WIDTH-1:1]};
          brw_q <= fs_borr;
          cnt   <= cnt + CW'(1);
          // Last bit: the cell's outputs this cycle complete the result, so capture directly.
          if (cnt == LAST) begin
            result     <= {fs_diff, r_sr[WIDTH-1:1]};
            borrow_out <= fs_borr;
            ovf        <= (a_msb != b_msb) && (fs_diff != a_msb);
            state      <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  assign fs_a = busy & a_sr[0];
  assign fs_b = busy & b_sr[0];
  assign fs_c = busy & brw_q;

endmodule

// File: tb/tb_serial_sub_seq.sv
// Directed bench for serial_sub_seq at WIDTH=8 and WIDTH=2, each with a behavioural full-subtractor cell.
module tb_serial_sub_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a_in = '0, b_in = '0;
  logic       ready, busy, done, borrow_out, ovf;
  logic [7:0] result;
  logic       fs_a, fs_b, fs_c, fs_diff, fs_borr;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       ready2, busy2, done2, borrow2, ovf2;
  logic [1:0] result2;
  logic       fa2, fb2, fc2, fd2, fbr2;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_fsc;

  always #5 clk = ~clk;

  // Reference full-subtractor cells: diff = A^B^C, borrow = (~A&B) | (~(A^B)&C)
  assign fs_diff = fs_a ^ fs_b ^ fs_c;
  assign fs_borr = (~fs_a & fs_b) | (~(fs_a ^ fs_b) & fs_c);
  assign fd2     = fa2 ^ fb2 ^ fc2;
  assign fbr2    = (~fa2 & fb2) | (~(fa2 ^ fb2) & fc2);

  serial_sub_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .ready(ready), .busy(busy), .done(done), .result(result),
    .borrow_out(borrow_out), .ovf(ovf),
    .fs_a(fs_a), .fs_b(fs_b), .fs_c(fs_c), .fs_diff(fs_diff), .fs_borr(fs_borr)
  );

  serial_sub_seq #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a_in(a2), .b_in(b2),
    .ready(ready2), .busy(busy2), .done(done2), .result(result2),
    .borrow_out(borrow2), .ovf(ovf2),
    .fs_a(fa2), .fs_b(fb2), .fs_c(fc2), .fs_diff(fd2), .fs_borr(fbr2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 30 && !ready; i++) @(negedge clk);
  endtask

  // One full operation on the 8-bit DUT; cycle n is the cycle after edge n-1 (accepting edge = 0).
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] er, input logic eb, input logic eo);
    int n;
    logic [7:0] fc;
    @(negedge clk);
    wait_ready();
    check({tag, "_rdy"}, ready, 1);
    a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a_in = ~a; b_in = ~b;
    n = 0; fc = '0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (n <= 8) fc[n-1] = fs_c;
      if (n == 1) check({tag, "_busy1"}, {ready, busy, done}, 3'b010);
      if (done) break;
    end
    last_fsc = fc;
    check({tag, "_lat"}, n, 9);
    check({tag, "_res"}, result, er);
    check({tag, "_brw"}, borrow_out, eb);
    check({tag, "_ovf"}, ovf, eo);
  endtask

  initial begin
    int n, dn;

    #12;
    check("rst_flags", {ready, busy, done}, 3'b100);
    check("rst_out", {result, borrow_out, ovf}, 10'h0);
    check("rst_cell", {fs_a, fs_b, fs_c}, 3'b000);
    @(negedge clk); rst = 1'b0;

    run8("basic", 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
    run8("uflow", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    check("uflow_fsc", last_fsc, 8'hFE);
    run8("sovf1", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run8("sovf2", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

    // start pulses in RUN (cycle 3) and DONE (cycle 9) must be dropped
    @(negedge clk); wait_ready();
    a_in = 8'h5A; b_in = 8'h3C; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    dn = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done && dn == 0) dn = c;
      start = (c == 3 || c == 9);
      a_in = 8'h11; b_in = 8'h22;
    end
    start = 1'b0;
    check("ign_lat", dn, 9);
    check("ign_res", result, 8'h1E);
    check("ign_idle", {ready, busy, done}, 3'b100);

    // held start: re-accepted at end of cycle 10, operands swapped after first accept
    @(negedge clk);
    a_in = 8'h80; b_in = 8'h01; start = 1'b1;
    @(posedge clk); #1 a_in = 8'h7F; b_in = 8'hFF;
    n = 0;
    while (n < 20) begin
      @(negedge clk); n++;
      if (done) break;
    end
    check("hold_lat1", n, 9);
    check("hold_res1", result, 8'h7F);
    @(negedge clk);
    check("hold_c10", {ready, busy, done}, 3'b100);
    @(negedge clk);
    check("hold_c11", {ready, busy, done}, 3'b010);
    start = 1'b0;
    n = 1;
    while (n < 20) begin
      @(negedge clk); n++;
      if (done) break;
    end
    check("hold_lat2", n, 9);
    check("hold_res2", {result, borrow_out, ovf}, {8'h80, 1'b1, 1'b1});

    // reset asserted in bit cycle 4
    @(negedge clk); wait_ready();
    a_in = 8'h5A; b_in = 8'h3C; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_flags", {ready, busy, done}, 3'b100);
    check("mid_out", {result, borrow_out, ovf}, 10'h0);
    check("mid_cell", {fs_a, fs_b, fs_c}, 3'b000);
    @(negedge clk);
    check("mid_nodone", done, 0);
    rst = 1'b0;
    run8("post", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);

    // WIDTH=2 instance
    @(negedge clk);
    check("w2_rdy", ready2, 1);
    a2 = 2'd2; b2 = 2'd3; start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    n = 0;
    while (n < 10) begin
      @(negedge clk); n++;
      if (done2) break;
    end
    check("w2_lat", n, 3);
    check("w2_res", {result2, borrow2, ovf2}, {2'd3, 1'b1, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
